// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path.
//   - trig_lvl encodings and the threshold they select
//   - RDR bit positions
//   - default character-timeout length
//   - rx_entry_t: one stored character (data plus error flags)
package uart_pkg;

    typedef enum logic [1:0] {
        TRIG_ONE     = 2'b00,  // threshold 1
        TRIG_QUARTER = 2'b01,  // threshold DEPTH/4
        TRIG_HALF    = 2'b10,  // threshold DEPTH/2
        TRIG_NEARFUL = 2'b11   // threshold DEPTH-2
    } trig_lvl_e;

    localparam int DATA_LSB = 0;
    localparam int PE_BIT   = 8;
    localparam int FE_BIT   = 9;
    localparam int NE_BIT   = 10;

    localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd4000;

    typedef struct packed {
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } rx_entry_t;

    // Interrupt threshold, in entries, for a trig_lvl setting.
    function automatic int unsigned trig_threshold(input logic [1:0] lvl,
                                                   input int unsigned depth);
        case (trig_lvl_e'(lvl))
            TRIG_ONE:     return 1;
            TRIG_QUARTER: return depth / 4;
            TRIG_HALF:    return depth / 2;
            default:      return depth - 2;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: DEPTH x rx_entry_t register array.
//   clk          system clock
//   we/waddr/wdata  synchronous write port
//   raddr/rdata     asynchronous read port
// No reset: contents are only meaningful behind the owner's count.
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  rx_entry_t       wdata,
    input  logic [AW-1:0]   raddr,
    output rx_entry_t       rdata
);

    rx_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive character buffer between a UART receiver and the
// register file. Presents the oldest entry as the RDR word, pops on rx_read,
// flags overrun, and raises a trigger-level (and optional timeout) interrupt.
//
// Optional feature: define UART_RX_TIMEOUT_EN to build the character-timeout
// idle counter; otherwise timeout is constant 0.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, wr_data    character strobe / byte from the receiver shifter
//   wr_pe, wr_fe      parity / framing error for that character
//   rx_read           pop strobe (CPU read of RDR)
//   sr_read           CPU read of SR, clears overrun
//   flush             empties the FIFO
//   trig_lvl          interrupt threshold select
//   rdr               {21'b0, not_empty, fe, pe, data} of the head entry
//   count, empty, full  occupancy
//   overrun           sticky: a character was dropped while full
//   timeout           sticky: data has sat idle for TIMEOUT_CYC clocks
//   int_rx            interrupt request
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter int          AW          = 4,
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          wr_pe,
    input  logic          wr_fe,
    input  logic          rx_read,
    input  logic          sr_read,
    input  logic          flush,
    input  logic [1:0]    trig_lvl,
    output logic [31:0]   rdr,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overrun,
    output logic          timeout,
    output logic          int_rx
);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_wr, do_rd, ovr_set;
    logic [AW:0]   thr;
    rx_entry_t     head, wr_entry;

    assign empty = (count == '0);
    assign full  = count[AW];

    // A write into a full FIFO is still accepted when a pop frees a slot in
    // the same cycle; full implies non-empty, so that pop is always valid.
    assign do_wr   = wr_en & ~flush & (~full | rx_read);
    assign do_rd   = rx_read & ~flush & ~empty;
    assign ovr_set = wr_en & ~flush & full & ~rx_read;

    assign wr_entry = '{fe: wr_fe, pe: wr_pe, data: wr_data};

    uart_rx_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + 1'b1;
                if (do_rd) rd_ptr <= rd_ptr + 1'b1;
                case ({do_wr, do_rd})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
            // Set wins over a same-cycle clear so a drop is never lost.
            if (ovr_set)      overrun <= 1'b1;
            else if (sr_read) overrun <= 1'b0;
        end
    end

    // Head word is masked to zero when empty so stale memory never leaks.
    always_comb begin
        rdr = '0;
        if (!empty) begin
            rdr[DATA_LSB +: 8] = head.data;
            rdr[PE_BIT]        = head.pe;
            rdr[FE_BIT]        = head.fe;
            rdr[NE_BIT]        = 1'b1;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        timeout_q;

    // timeout is raised on the edge that brings idle_cnt to TIMEOUT_CYC, so
    // it is visible exactly TIMEOUT_CYC clocks after the last activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (wr_en || rx_read || flush || empty) begin
                idle_cnt <= '0;
            end else if (idle_cnt != TIMEOUT_CYC) begin
                idle_cnt <= idle_cnt + 16'd1;
                if (idle_cnt + 16'd1 == TIMEOUT_CYC) timeout_q <= 1'b1;
            end
            if (rx_read || flush) timeout_q <= 1'b0;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign thr    = (AW+1)'(trig_threshold(trig_lvl, DEPTH));
    assign int_rx = (count >= thr) | timeout;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
// (DEPTH=16, TIMEOUT_CYC=20). Inputs change 1 time unit after the rising
// edge; outputs are checked at that same point, after the edge has settled.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, wr_pe, wr_fe, rx_read, sr_read, flush;
    logic [7:0]  wr_data;
    logic [1:0]  trig_lvl;
    logic [31:0] rdr;
    logic [4:0]  count;
    logic        empty, full, overrun, timeout, int_rx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .AW(4), .TIMEOUT_CYC(16'd20)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_pe(wr_pe), .wr_fe(wr_fe), .rx_read(rx_read), .sr_read(sr_read),
        .flush(flush), .trig_lvl(trig_lvl), .rdr(rdr), .count(count),
        .empty(empty), .full(full), .overrun(overrun), .timeout(timeout),
        .int_rx(int_rx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given strobes; all strobes drop afterwards.
    task automatic step(input logic w, input logic [7:0] d, input logic rd,
                        input logic sr, input logic fl);
        wr_en = w; wr_data = d; rx_read = rd; sr_read = sr; flush = fl;
        tick();
        wr_en = 1'b0; rx_read = 1'b0; sr_read = 1'b0; flush = 1'b0;
        wr_pe = 1'b0; wr_fe = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; wr_pe = 1'b0; wr_fe = 1'b0;
        rx_read = 1'b0; sr_read = 1'b0; flush = 1'b0; trig_lvl = 2'b11;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_empty",   32'(empty),   32'd1);
        chk("rst_full",    32'(full),    32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_int",     32'(int_rx),  32'd0);
        chk("rst_rdr",     rdr,          32'h0);

        // basic order
        wr(8'h41);
        chk("wr1_rdr", rdr, 32'h441);
        wr(8'h42);
        chk("wr2_rdr",   rdr,          32'h441);
        chk("wr2_count", 32'(count),   32'd2);
        pop();
        chk("pop1_rdr", rdr, 32'h442);
        pop();
        chk("pop2_rdr",   rdr,        32'h0);
        chk("pop2_empty", 32'(empty), 32'd1);

        // pop on empty is ignored
        pop();
        chk("underflow_count", 32'(count), 32'd0);
        wr(8'h33);
        chk("after_underflow_rdr", rdr, 32'h433);
        pop();

        // write and pop together while empty
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        chk("empty_wrrd_count", 32'(count), 32'd1);
        chk("empty_wrrd_rdr",   rdr,        32'h45A);
        pop();

        // error flags
        wr_pe = 1'b1; wr_fe = 1'b1;
        wr(8'h55);
        chk("errflags_rdr", rdr, 32'h755);
        pop();
        wr_pe = 1'b1;
        wr(8'hA0);
        chk("pe_only_rdr", rdr, 32'h5A0);
        pop();

        // trigger level 01 -> 4 entries
        trig_lvl = 2'b01;
        wr(8'h01); wr(8'h02); wr(8'h03);
        chk("trig_3_int", 32'(int_rx), 32'd0);
        wr(8'h04);
        chk("trig_4_int", 32'(int_rx), 32'd1);
        pop();
        chk("trig_pop_int", 32'(int_rx), 32'd0);
        trig_lvl = 2'b00; #1;
        chk("trig00_int", 32'(int_rx), 32'd1);
        trig_lvl = 2'b10; #1;
        chk("trig10_int", 32'(int_rx), 32'd0);
        trig_lvl = 2'b11;
        pop(); pop(); pop();
        chk("trig_drain_empty", 32'(empty), 32'd1);

        // fill to full
        for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
        chk("fill_full",    32'(full),    32'd1);
        chk("fill_count",   32'(count),   32'd16);
        chk("fill_overrun", 32'(overrun), 32'd0);
        chk("fill_int14",   32'(int_rx),  32'd1);

        // full: write and pop together
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        chk("full_wrrd_count",   32'(count),   32'd16);
        chk("full_wrrd_overrun", 32'(overrun), 32'd0);
        chk("full_wrrd_rdr",     rdr,          32'h411);

        // 17th byte dropped
        wr(8'h20);
        chk("ovr_overrun", 32'(overrun), 32'd1);
        chk("ovr_count",   32'(count),   32'd16);
        chk("ovr_full",    32'(full),    32'd1);
        chk("ovr_rdr",     rdr,          32'h411);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("sr_clear", 32'(overrun), 32'd0);
        step(1'b1, 8'h21, 1'b0, 1'b1, 1'b0);
        chk("set_beats_clear", 32'(overrun), 32'd1);

        // drain 11, checking order (0x11..0x1B)
        for (int i = 0; i < 11; i++) begin
            chk("drain_rdr", rdr, 32'h400 | 32'(8'h11 + i));
            pop();
        end
        chk("five_count", 32'(count), 32'd5);
        chk("five_rdr",   rdr,        32'h41C);

        // flush with a same-cycle write
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("flush_count",   32'(count),   32'd0);
        chk("flush_empty",   32'(empty),   32'd1);
        chk("flush_overrun", 32'(overrun), 32'd1);
        chk("flush_rdr",     rdr,          32'h0);
        wr(8'h77);
        chk("post_flush_rdr", rdr, 32'h477);
        wr(8'h78);

        // reset mid-stream beats a same-cycle write
        trig_lvl = 2'b00;
        rst = 1'b1;
        step(1'b1, 8'h79, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("mrst_count",   32'(count),   32'd0);
        chk("mrst_empty",   32'(empty),   32'd1);
        chk("mrst_full",    32'(full),    32'd0);
        chk("mrst_overrun", 32'(overrun), 32'd0);
        chk("mrst_int",     32'(int_rx),  32'd0);
        chk("mrst_rdr",     rdr,          32'h0);
        trig_lvl = 2'b11;

`ifdef UART_RX_TIMEOUT_EN
        wr(8'hAB);
        for (int i = 0; i < 19; i++) tick();
        chk("to_19_timeout", 32'(timeout), 32'd0);
        chk("to_19_int",     32'(int_rx),  32'd0);
        tick();
        chk("to_20_timeout", 32'(timeout), 32'd1);
        chk("to_20_int",     32'(int_rx),  32'd1);
        tick(); tick();
        chk("to_hold",       32'(timeout), 32'd1);
        pop();
        chk("to_pop_timeout", 32'(timeout), 32'd0);
        chk("to_pop_int",     32'(int_rx),  32'd0);
        wr(8'hAC);
        for (int i = 0; i < 20; i++) tick();
        chk("to2_timeout", 32'(timeout), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("to_flush_timeout", 32'(timeout), 32'd0);
`else
        wr(8'hAB);
        for (int i = 0; i < 25; i++) tick();
        chk("noto_timeout", 32'(timeout), 32'd0);
        chk("noto_int",     32'(int_rx),  32'd0);
        pop();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
